// File: rtl/irq_arb_if.sv
// Interrupt arbiter bus: raw lines, enables and core handshake in; offer, pending and overrun out.
// Latency: none (wires only).
// Backpressure: the core holds the offer with ack low; ack is meaningful only while irq_valid is high.
interface irq_arb_if #(
  parameter int NSRC = 3
) ();
  logic [NSRC-1:0] src;
  logic [NSRC-1:0] src_en;
  logic            gie;
  logic            boundary;
  logic            ack;
  logic [NSRC-1:0] clr_ovr;
  logic            irq_valid;
  logic [3:0]      irq_id;
  logic [63:0]     irq_cause;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] ovr;

  // Core side: drives lines and handshake, observes the offer
  modport master (
    output src, src_en, gie, boundary, ack, clr_ovr,
    input  irq_valid, irq_id, irq_cause, pend, ovr
  );

  // Arbiter side
  modport slave (
    input  src, src_en, gie, boundary, ack, clr_ovr,
    output irq_valid, irq_id, irq_cause, pend, ovr
  );
endinterface

// File: rtl/irq_arb.sv
// Interrupt arbiter: edge/level pending capture, lowest-index priority, frozen offer until ack or withdraw.
// Latency: line edge -> pend +1 cycle -> irq_valid +2 cycles; one holdoff cycle after every ack.
// Backpressure: offer is held until ack; optional overrun tracking under macro IRQ_ARB_OVERRUN_EN.
module irq_arb #(
  parameter int                NSRC      = 3,
  parameter logic [NSRC*8-1:0] CAUSE_MAP = {8'd11, 8'd3, 8'd7},
  parameter logic [NSRC-1:0]   EDGE_MASK = {NSRC{1'b1}}
) (
  input logic      clk,
  input logic      reset,
  irq_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OFFER   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NSRC-1:0] src_q;          // one-cycle delayed copy of the raw lines
  logic [NSRC-1:0] epend_q, epend_d;
  logic [3:0]      id_q, id_d;

  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_w;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] id_oh;
  logic [NSRC-1:0] ack_clr;
  logic [3:0]      pick_id;
  logic [7:0]      cause_code;
  logic            ack_take;
  logic            lat_elig;

  assign rise     = bus.src & ~src_q;
  // Level sources mirror the delayed line; edge sources use the sticky flag.
  assign pend_w   = (epend_q & EDGE_MASK) | (src_q & ~EDGE_MASK);
  assign elig     = bus.gie ? (pend_w & bus.src_en) : '0;
  assign ack_take = (state_q == S_OFFER) && bus.ack;
  assign ack_clr  = ack_take ? id_oh : '0;
  assign lat_elig = |(elig & id_oh);

  // Decode latched id to one-hot and look up its cause code
  always_comb begin
    id_oh      = '0;
    cause_code = 8'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_q == 4'(i)) begin
        id_oh[i]   = 1'b1;
        cause_code = CAUSE_MAP[i*8 +: 8];
      end
    end
  end

  // Lowest eligible index wins
  always_comb begin
    pick_id = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) pick_id = 4'(i);
    end
  end

  // Edge pending: a fresh edge beats the ack clear in the same cycle
  always_comb begin
    epend_d = ((epend_q & ~ack_clr) | rise) & EDGE_MASK;
  end

  // Offer FSM: next state and id latch
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if ((elig != '0) && bus.boundary) begin
          state_d = S_OFFER;
          id_d    = pick_id;
        end
      end
      S_OFFER: begin
        if (bus.ack)       state_d = S_HOLDOFF;
        else if (!lat_elig) state_d = S_IDLE;
      end
      S_HOLDOFF: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State, line history, pending and id registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      epend_q <= '0;
      id_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      src_q   <= bus.src;
      epend_q <= epend_d;
      id_q    <= id_d;
    end
  end

`ifdef IRQ_ARB_OVERRUN_EN
  logic [NSRC-1:0] ovr_q, ovr_d;

  // Overrun: an edge arriving while the edge source is still pending; set beats clear
  always_comb begin
    ovr_d = (ovr_q & ~bus.clr_ovr) | (rise & epend_q & EDGE_MASK);
  end

  // Overrun flag register
  always_ff @(posedge clk) begin
    if (!reset) ovr_q <= '0;
    else        ovr_q <= ovr_d;
  end

  assign bus.ovr = ovr_q;
`else
  assign bus.ovr = '0;
`endif

  assign bus.irq_valid = (state_q == S_OFFER);
  assign bus.irq_id    = id_q;
  assign bus.irq_cause = {1'b1, 55'd0, cause_code};
  assign bus.pend      = pend_w;

endmodule

// File: tb/tb_irq_arb.sv
// Bench for irq_arb: reference model on the default instance plus directed literal checks.
// Latency: model tracks DUT cycle by cycle; outputs compared every falling edge.
// Backpressure: ack driven by stimulus; every wait for an offer is cycle-bounded.
module tb_irq_arb;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  irq_arb_if #(.NSRC(3)) bi ();
  irq_arb_if #(.NSRC(3)) bl ();

  irq_arb #(.NSRC(3)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bi)
  );

  irq_arb #(.NSRC(3), .EDGE_MASK(3'b110)) dut_lvl (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: cause codes per source, sticky pending, offer status
  int         cause_tab [3] = '{7, 3, 11};
  logic [2:0] m_prev = '0;
  logic [2:0] m_pe   = '0;
  logic [2:0] m_ovr  = '0;
  bit         m_off  = 0;
  bit         m_cool = 0;
  int         m_id   = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_prev = '0; m_pe = '0; m_ovr = '0;
      m_off = 0; m_cool = 0; m_id = 0;
    end else begin : mdl
      logic [2:0] rise;
      logic [2:0] elig;
      logic [2:0] nxt;
      int low;
      bit acked;
      rise  = bi.src & ~m_prev;
      elig  = bi.gie ? (m_pe & bi.src_en) : 3'b000;
      low   = -1;
      for (int i = 2; i >= 0; i--) if (elig[i]) low = i;
      acked = 0;
      if (m_cool) m_cool = 0;
      else if (m_off) begin
        if (bi.ack) begin acked = 1; m_off = 0; m_cool = 1; end
        else if (!elig[m_id]) m_off = 0;
      end else if (low >= 0 && bi.boundary) begin
        m_off = 1; m_id = low;
      end
      nxt = m_pe | rise;
      if (acked) nxt[m_id] = rise[m_id];
      m_ovr  = (m_ovr & ~bi.clr_ovr) | (rise & m_pe);
      m_pe   = nxt;
      m_prev = bi.src;
    end
  end

  // Every-cycle comparison of the default instance against the model
  always @(negedge clk) begin
    chk("m_valid", 64'(bi.irq_valid), 64'(m_off));
    chk("m_id",    64'(bi.irq_id),    64'(m_id));
    chk("m_cause", bi.irq_cause,      64'h8000_0000_0000_0000 | 64'(cause_tab[m_id]));
    chk("m_pend",  64'(bi.pend),      64'(m_pe));
`ifdef IRQ_ARB_OVERRUN_EN
    chk("m_ovr",   64'(bi.ovr),       64'(m_ovr));
`else
    chk("m_ovr",   64'(bi.ovr),       64'd0);
`endif
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for an offer, check its id, ack it and let holdoff pass
  task automatic serve(input int exp_id);
    int n = 0;
    while (!bi.irq_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bi.irq_valid) chk("serve_timeout", 64'd0, 64'd1);
    else               chk("serve_id", 64'(bi.irq_id), 64'(exp_id));
    bi.ack = 1'b1;
    step(1);
    bi.ack = 1'b0;
    step(1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bi.src = '0; bi.src_en = '0; bi.gie = 1'b0; bi.boundary = 1'b0; bi.ack = 1'b0; bi.clr_ovr = '0;
    bl.src = '0; bl.src_en = '0; bl.gie = 1'b0; bl.boundary = 1'b0; bl.ack = 1'b0; bl.clr_ovr = '0;
    step(3);
    chk("rst_valid", 64'(bi.irq_valid), 64'd0);
    chk("rst_pend",  64'(bi.pend),      64'd0);
    chk("rst_ovr",   64'(bi.ovr),       64'd0);
    chk("rst_id",    64'(bi.irq_id),    64'd0);
    rst_n = 1'b1;
    bi.src_en = 3'b111; bi.gie = 1'b1; bi.boundary = 1'b1;
    step(1);

    // Single edge on source 2
    bi.src = 3'b100; step(1);
    chk("e2_pend", 64'(bi.pend), 64'b100);
    chk("e2_nooffer_yet", 64'(bi.irq_valid), 64'd0);
    bi.src = '0; step(1);
    chk("e2_valid", 64'(bi.irq_valid), 64'd1);
    chk("e2_id",    64'(bi.irq_id),    64'd2);
    chk("e2_cause", bi.irq_cause,      64'h8000_0000_0000_000B);
    bi.ack = 1'b1; step(1);
    bi.ack = 1'b0;
    chk("e2_pend_clr", 64'(bi.pend),      64'd0);
    chk("e2_holdoff",  64'(bi.irq_valid), 64'd0);
    step(1);
    chk("e2_idle", 64'(bi.irq_valid), 64'd0);

    // Sources 0 and 1 together
    bi.src = 3'b011; step(1);
    bi.src = '0; step(1);
    chk("p01_id",    64'(bi.irq_id),    64'd0);
    chk("p01_cause", bi.irq_cause,      64'h8000_0000_0000_0007);
    bi.ack = 1'b1; step(1);
    bi.ack = 1'b0;
    chk("p01_pend", 64'(bi.pend), 64'b010);
    step(1);
    chk("p01_gap", 64'(bi.irq_valid), 64'd0);
    step(1);
    chk("p1_valid", 64'(bi.irq_valid), 64'd1);
    chk("p1_id",    64'(bi.irq_id),    64'd1);
    chk("p1_cause", bi.irq_cause,      64'h8000_0000_0000_0003);
    bi.ack = 1'b1; step(1);
    bi.ack = 1'b0; step(1);

    // Offer stays frozen when a higher-priority source arrives
    bi.src = 3'b100; step(1);
    bi.src = '0; step(1);
    chk("frz_id0", 64'(bi.irq_id), 64'd2);
    bi.src = 3'b001; step(1);
    bi.src = '0;
    chk("frz_pend", 64'(bi.pend),   64'b101);
    chk("frz_id1",  64'(bi.irq_id), 64'd2);
    step(1);
    chk("frz_id2", 64'(bi.irq_id), 64'd2);
    bi.ack = 1'b1; step(1);
    bi.ack = 1'b0;
    chk("frz_pend_after", 64'(bi.pend), 64'b001);
    step(2);
    chk("frz_next_valid", 64'(bi.irq_valid), 64'd1);
    chk("frz_next_id",    64'(bi.irq_id),    64'd0);

    // New edge in the same cycle as its ack keeps it pending
    bi.ack = 1'b1; bi.src = 3'b001; step(1);
    bi.ack = 1'b0;
    chk("ack_edge_pend", 64'(bi.pend), 64'b001);
    bi.src = '0; bi.clr_ovr = 3'b001; step(1);
    bi.clr_ovr = '0;
    serve(0);

    // No offer outside an instruction boundary
    bi.boundary = 1'b0; bi.src = 3'b010; step(1);
    bi.src = '0;
    chk("bnd_pend", 64'(bi.pend), 64'b010);
    step(3);
    chk("bnd_hold", 64'(bi.irq_valid), 64'd0);
    bi.boundary = 1'b1;
    serve(1);

    // Global disable, stray ack, then enable
    bi.gie = 1'b0; bi.src = 3'b111; step(1);
    bi.src = '0;
    chk("gie_pend", 64'(bi.pend), 64'b111);
    bi.ack = 1'b1; step(1);
    bi.ack = 1'b0;
    chk("stray_ack_pend", 64'(bi.pend),      64'b111);
    chk("gie_off_valid",  64'(bi.irq_valid), 64'd0);
    step(2);
    chk("gie_off_valid2", 64'(bi.irq_valid), 64'd0);
    bi.gie = 1'b1; step(1);
    chk("gie_on_valid", 64'(bi.irq_valid), 64'd1);
    chk("gie_on_id",    64'(bi.irq_id),    64'd0);
    serve(0);
    serve(1);
    serve(2);

    // Overrun on source 1
    bi.gie = 1'b0; bi.src = 3'b010; step(1);
    bi.src = '0; step(1);
    bi.src = 3'b010; step(1);
    bi.src = '0;
`ifdef IRQ_ARB_OVERRUN_EN
    chk("ovr_set", 64'(bi.ovr), 64'b010);
`else
    chk("ovr_set", 64'(bi.ovr), 64'b000);
`endif
    chk("ovr_pend", 64'(bi.pend), 64'b010);
    bi.clr_ovr = 3'b010; step(1);
    bi.clr_ovr = '0;
    chk("ovr_clr", 64'(bi.ovr), 64'd0);
    bi.gie = 1'b1;
    serve(1);

    // Reset during an offer
    bi.src = 3'b100; step(1);
    bi.src = '0; step(1);
    chk("rmo_valid", 64'(bi.irq_valid), 64'd1);
    rst_n = 1'b0; bi.ack = 1'b1; step(1);
    chk("rmo_drop", 64'(bi.irq_valid), 64'd0);
    chk("rmo_pend", 64'(bi.pend),      64'd0);
    chk("rmo_id",   64'(bi.irq_id),    64'd0);
    rst_n = 1'b1; bi.ack = 1'b0; step(1);
    chk("rmo_after", 64'(bi.irq_valid), 64'd0);

    // Level-triggered source 0 on the second instance
    bl.src_en = 3'b111; bl.gie = 1'b1; bl.boundary = 1'b1; bl.src = 3'b001; step(1);
    chk("lvl_pend",    64'(bl.pend),      64'b001);
    chk("lvl_novalid", 64'(bl.irq_valid), 64'd0);
    step(1);
    chk("lvl_valid", 64'(bl.irq_valid), 64'd1);
    chk("lvl_cause", bl.irq_cause,      64'h8000_0000_0000_0007);
    bl.ack = 1'b1; step(1);
    bl.ack = 1'b0;
    chk("lvl_ack_keeps", 64'(bl.pend),      64'b001);
    chk("lvl_holdoff",   64'(bl.irq_valid), 64'd0);
    step(2);
    chk("lvl_reoffer", 64'(bl.irq_valid), 64'd1);
    bl.src = '0; step(1);
    chk("lvl_pend_low", 64'(bl.pend), 64'd0);
    step(1);
    chk("lvl_withdraw", 64'(bl.irq_valid), 64'd0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
